// File: rtl/aesl_deadlock_watchdog.sv
// Kernel deadlock watchdog: latches a block once every dataflow instance has sat
// idle-or-blocked, with an unchanged block vector, for THRESHOLD consecutive cycles.
module aesl_deadlock_watchdog #(
    parameter int N_INST    = 3,
    parameter int N_AXIS    = 1,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 8
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_pulse,
    output logic [N_INST-1:0] block_inst_snap,
    output logic [N_AXIS-1:0] block_axis_snap,
    output logic [7:0]        event_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } fsm_t;

    localparam logic [CNT_W:0] THR = (CNT_W+1)'(THRESHOLD);

    fsm_t              state_q, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [CNT_W:0]    cnt_inc;
    logic [N_INST-1:0] prev_blk;
    logic              cond;
    logic              detect;

    assign cond    = (&(inst_idle_sigs | inst_block_sigs)) &
                     ((|inst_block_sigs) | (|axis_block_sigs));
    assign cnt_inc = {1'b0, cnt} + 1'b1;

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt;
        detect     = 1'b0;
        // clear outranks every transition, including a coincident detection
        if (clear) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cond) begin
                        cnt_next = CNT_W'(1);
                        if (THRESHOLD == 1) begin
                            state_next = ST_BLOCKED;
                            detect     = 1'b1;
                        end else begin
                            state_next = ST_SUSPECT;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                ST_SUSPECT: begin
                    if (!cond) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (inst_block_sigs == prev_blk) begin
                        cnt_next = cnt_inc[CNT_W-1:0];
                        if (cnt_inc == THR) begin
                            state_next = ST_BLOCKED;
                            detect     = 1'b1;
                        end
                    end else begin
                        cnt_next = CNT_W'(1);
                    end
                end
                ST_BLOCKED: state_next = ST_BLOCKED;
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            state_q         <= ST_IDLE;
            cnt             <= '0;
            prev_blk        <= '0;
            block           <= 1'b0;
            block_pulse     <= 1'b0;
            block_inst_snap <= '0;
            block_axis_snap <= '0;
            event_count     <= '0;
        end else begin
            state_q     <= state_next;
            cnt         <= cnt_next;
            prev_blk    <= inst_block_sigs;
            block       <= (state_next == ST_BLOCKED);
            block_pulse <= detect;
            if (detect) begin
                block_inst_snap <= inst_block_sigs;
                block_axis_snap <= axis_block_sigs;
                if (event_count != 8'hFF) begin
                    event_count <= event_count + 8'd1;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// Bench for aesl_deadlock_watchdog: directed scenarios plus random traffic, all
// checked against a streak-counting reference model.
module tb_aesl_deadlock_watchdog;

    localparam int NI = 3;
    localparam int NA = 1;
    localparam int TH = 4;

    logic          clk;
    logic          rst;
    logic [NA-1:0] axis_blk;
    logic [NI-1:0] idle;
    logic [NI-1:0] blk;
    logic          clr;
    logic          block;
    logic          block_pulse;
    logic [NI-1:0] block_inst_snap;
    logic [NA-1:0] block_axis_snap;
    logic [7:0]    event_count;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: length of the current stable qualifying run plus latch
    int            streak;
    bit            latched;
    bit            m_pulse;
    logic [NI-1:0] m_prev;
    logic [NI-1:0] m_isnap;
    logic [NA-1:0] m_asnap;
    int            m_count;

    aesl_deadlock_watchdog #(
        .N_INST   (NI),
        .N_AXIS   (NA),
        .THRESHOLD(TH),
        .CNT_W    (8)
    ) dut (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .axis_block_sigs     (axis_blk),
        .inst_idle_sigs      (idle),
        .inst_block_sigs     (blk),
        .clear               (clr),
        .block               (block),
        .block_pulse         (block_pulse),
        .block_inst_snap     (block_inst_snap),
        .block_axis_snap     (block_axis_snap),
        .event_count         (event_count),
        .state               (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        streak  = 0;
        latched = 0;
        m_pulse = 0;
        m_prev  = '0;
        m_isnap = '0;
        m_asnap = '0;
        m_count = 0;
    endtask

    task automatic model_step(input logic [NI-1:0] i, input logic [NI-1:0] b,
                              input logic [NA-1:0] a, input logic c);
        bit q;
        q = 1;
        for (int k = 0; k < NI; k++) if (!(i[k] || b[k])) q = 0;
        q = q && (b != 0 || a != 0);
        m_pulse = 0;
        if (latched) begin
            if (c) begin
                latched = 0;
                streak  = 0;
            end
        end else if (c || !q) begin
            streak = 0;
        end else begin
            if (streak > 0 && b != m_prev) streak = 1;
            else streak = streak + 1;
            if (streak == TH) begin
                latched = 1;
                m_pulse = 1;
                m_isnap = b;
                m_asnap = a;
                if (m_count < 255) m_count = m_count + 1;
            end
        end
        m_prev = b;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 32'(state), latched ? 32'd2 : (streak > 0 ? 32'd1 : 32'd0));
        check({tag, "_block"}, 32'(block), 32'(latched));
        check({tag, "_pulse"}, 32'(block_pulse), 32'(m_pulse));
        check({tag, "_isnap"}, 32'(block_inst_snap), 32'(m_isnap));
        check({tag, "_asnap"}, 32'(block_axis_snap), 32'(m_asnap));
        check({tag, "_count"}, 32'(event_count), 32'(m_count));
    endtask

    task automatic cycle(input string tag, input logic [NI-1:0] i, input logic [NI-1:0] b,
                         input logic [NA-1:0] a, input logic c);
        idle     = i;
        blk      = b;
        axis_blk = a;
        clr      = c;
        @(posedge clk);
        model_step(i, b, a, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [NI-1:0] ri, rb;
        logic [NA-1:0] ra;

        rst = 1'b1; idle = '0; blk = '0; axis_blk = '0; clr = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        check_all("reset");
        rst = 1'b0;

        // hold a qualifying, stable pattern until detection
        for (int n = 0; n < TH; n++) cycle("detect", 3'b010, 3'b101, 1'b0, 1'b0);
        check("detect_block_const", 32'(block), 32'd1);
        check("detect_snap_const", 32'(block_inst_snap), 32'h5);
        cycle("after_detect", 3'b010, 3'b101, 1'b0, 1'b0);
        check("pulse_one_cycle", 32'(block_pulse), 32'd0);

        // sticky while busy, released by clear with snapshots retained
        for (int n = 0; n < 3; n++) cycle("busy_latched", 3'b000, 3'b000, 1'b0, 1'b0);
        cycle("clear_rel", 3'b000, 3'b000, 1'b0, 1'b1);
        check("clear_count_kept", 32'(event_count), 32'd1);

        // qualification broken before threshold by a busy instance
        for (int n = 0; n < TH-1; n++) cycle("break", 3'b110, 3'b001, 1'b0, 1'b0);
        cycle("break_busy", 3'b000, 3'b001, 1'b0, 1'b0);

        // blocked vector keeps changing: progress restart, never detected
        for (int n = 0; n < 20; n++)
            if ((n / 2) % 2 == 0) cycle("toggle", 3'b110, 3'b001, 1'b0, 1'b0);
            else                  cycle("toggle", 3'b100, 3'b011, 1'b0, 1'b0);
        check("toggle_suspect", 32'(state), 32'd1);
        cycle("toggle_exit", 3'b000, 3'b000, 1'b0, 1'b0);

        // clear on the detecting edge suppresses the detection
        for (int n = 0; n < TH-1; n++) cycle("clr_edge", 3'b011, 3'b100, 1'b1, 1'b0);
        cycle("clr_edge_hit", 3'b011, 3'b100, 1'b1, 1'b1);
        check("clr_edge_count", 32'(event_count), 32'd1);

        // async reset mid-BLOCKED, between edges
        for (int n = 0; n < TH; n++) cycle("pre_arst", 3'b000, 3'b111, 1'b1, 1'b0);
        #3; rst = 1'b1; #1;
        model_reset();
        check_all("arst_immediate");
        idle = '0; blk = '0; axis_blk = '0; clr = 1'b0;
        @(posedge clk); #2; rst = 1'b0;
        check_all("arst_hold");

        // 256 detect/clear rounds: count saturates
        for (int r = 0; r < 256; r++) begin
            for (int n = 0; n < TH; n++) cycle("sat", 3'b001, 3'b110, 1'b0, 1'b0);
            cycle("sat_clr", 3'b001, 3'b110, 1'b0, 1'b1);
        end
        check("sat_255", 32'(event_count), 32'd255);

        // random traffic, vectors held for a few cycles so streaks can form
        rb = 3'b001; ri = 3'b110; ra = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                rb = NI'($urandom_range(0, 7));
                ri = ~rb;
                if ($urandom_range(0, 3) == 0) ri = NI'($urandom_range(0, 7));
                ra = NA'($urandom_range(0, 3) == 0);
            end
            cycle("rand", ri, rb, ra, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aesl_deadlock_watchdog.md
AESL_DEADLOCK_WATCHDOG -- requirements
Module: aesl_deadlock_watchdog

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; the clock port is kernel_monitor_clock and the reset port is kernel_monitor_reset.
REQ-002 SHALL have parameter N_INST, default 3: number of monitored dataflow instances, range 1..64.
REQ-003 SHALL have parameter N_AXIS, default 1: number of monitored AXI-Stream ports, range 1..32.
REQ-004 SHALL have parameter THRESHOLD, default 16: consecutive qualifying cycles before block is declared, range 1..2^CNT_W-1.
REQ-005 SHALL have parameter CNT_W, default 8: width of the qualification counter.
REQ-006 SHALL have port kernel_monitor_clock, input, 1 bit: clock.
REQ-007 SHALL have port kernel_monitor_reset, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port axis_block_sigs, input, N_AXIS bits: per-port AXIS blocked.
REQ-009 SHALL have port inst_idle_sigs, input, N_INST bits: per-instance ap_idle.
REQ-010 SHALL have port inst_block_sigs, input, N_INST bits: per-instance blocked (done without continue, or FIFO blk_n low).
REQ-011 SHALL have port clear, input, 1 bit: synchronous release of a latched block.
REQ-012 SHALL have port block, output, 1 bit: kernel deadlock latched.
REQ-013 SHALL have port block_pulse, output, 1 bit: one-cycle strobe on entry to BLOCKED.
REQ-014 SHALL have port block_inst_snap, output, N_INST bits: inst_block_sigs captured at detection.
REQ-015 SHALL have port block_axis_snap, output, N_AXIS bits: axis_block_sigs captured at detection.
REQ-016 SHALL have port event_count, output, 8 bits: saturating count of detections.
REQ-017 SHALL have port state, output, 2 bits: IDLE=0, SUSPECT=1, BLOCKED=2.

Function
REQ-018 SHALL compute cond = AND over i of (inst_idle_sigs[i] | inst_block_sigs[i]), ANDed with (OR of inst_block_sigs | OR of axis_block_sigs); all-idle with nothing blocked is not cond.
REQ-019 SHALL register prev_blk, the previous cycle's inst_block_sigs, for stability checking.
REQ-020 SHALL behave as follows in IDLE: cond → cnt=1, then BLOCKED if THRESHOLD==1, else SUSPECT; !cond → stay, cnt=0.
REQ-021 SHALL behave as follows in SUSPECT: !cond → IDLE, cnt=0; cond with inst_block_sigs==prev_blk → cnt+1, entering BLOCKED when cnt+1==THRESHOLD; cond with a changed vector → cnt=1, stay SUSPECT (a progress restart).
REQ-022 SHALL make BLOCKED sticky: the FSM stays in BLOCKED regardless of cond until clear; on clear it goes to IDLE with cnt=0.
REQ-023 SHALL give clear priority over every transition: clear while in IDLE or SUSPECT forces IDLE with cnt=0, and clear coincident with a detection edge suppresses the detection (no pulse, no count, no snapshot).
REQ-024 SHALL assert block in the cycle after the THRESHOLD-th consecutive qualifying edge, i.e. a latency of THRESHOLD cycles from the first cond cycle.
REQ-025 SHALL, on entry to BLOCKED, load block_inst_snap/block_axis_snap from the inputs sampled at the detecting edge, hold them until the next detection, and keep them unchanged on clear.
REQ-026 SHALL assert block_pulse for exactly one cycle per entry to BLOCKED.
REQ-027 SHALL increment event_count on each entry to BLOCKED, saturate it at 255, and leave it unaffected by clear.
REQ-028 SHALL keep the counter width-safe: cnt never exceeds THRESHOLD and has no wrap-around.
REQ-029 SHALL make block, block_pulse, snapshots and state registered outputs, with no combinational path from inputs.

Reset
REQ-030 SHALL, on kernel_monitor_reset high at any time including mid-SUSPECT or BLOCKED, force state=IDLE, cnt=0, prev_blk=0, block=0, block_pulse=0, block_inst_snap=0, block_axis_snap=0, event_count=0.
REQ-031 SHALL evaluate the first edge after reset release with prev_blk=0.

Verification (N_INST=3, N_AXIS=1, THRESHOLD=4)
REQ-032 SHALL cover: idle=3'b010, blk=3'b101, axis=0 held → state goes 1 at edge 1, block=1 after edge 4, block_pulse one cycle, snap=3'b101, event_count=1.
REQ-033 SHALL cover: cond for 3 cycles, then idle=3'b000 with blk=3'b001 → IDLE, block stays 0, cnt=0.
REQ-034 SHALL cover: cond with blk toggling 3'b001 ↔ 3'b011 every 2 cycles for 20 cycles → never BLOCKED, state remains SUSPECT.
REQ-035 SHALL cover: latched BLOCKED, inputs go all-busy, then clear=1 for 1 cycle → block stays 1 until clear, then 0, with snapshots and event_count=1 retained.
REQ-036 SHALL cover: clear asserted on the 4th qualifying edge → no detection, event_count=0; 256 detect/clear cycles → event_count=255.
REQ-037 SHALL cover: reset asserted asynchronously mid-BLOCKED, between clock edges → all outputs 0 immediately, before the next clock edge.
